// File: rtl/vme_wb_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-VME memory-strobe bridge.
package vme_wb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    ACK,
    ERR
  } state_t;

  // Only full-word writes are forwarded downstream.
  localparam logic [3:0] SEL_FULL = 4'hF;

  // Width of the wait-state counter; bounds TIMEOUT_CYCLES to 1..65535.
  localparam int unsigned TMO_WIDTH = 16;

endpackage

// File: rtl/vme_wb_timeout.sv
// Wait-state counter for the bridge: cleared outside WAIT, counts each WAIT
// cycle, and flags the TIMEOUT_CYCLES-th wait cycle that passes without Done.
module vme_wb_timeout
  import vme_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic Clk,
  input  logic RstN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_WIDTH-1:0] LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TMO_WIDTH-1:0] count;

  // Count wait cycles, holding at the terminal value so it never wraps.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + TMO_WIDTH'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/vme_wb_bridge.sv
// Wishbone-classic slave to VME-style memory-strobe master bridge.
// Optional feature macro: VME_WB_BRIDGE_TIMEOUT_EN (abort hung accesses
// after TIMEOUT_CYCLES wait cycles). Without it the bridge waits forever.
module vme_wb_bridge
  import vme_wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  output logic [31:0]           VMEWrData,
  input  logic [31:0]           VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone
);

  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t state_q, state_d;
  logic   abort_q, abort_d;
  logic   rd_mem_d, wr_mem_d;
  logic   lat_addr, lat_wdata, lat_rdata;
  logic   in_wait, dropped, tmo_expired;

  assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  // A master that leaves during WAIT forfeits the response, even if it
  // leaves in the very cycle Done arrives.
  assign dropped = abort_q || !wb_cyc_i;

`ifdef VME_WB_BRIDGE_TIMEOUT_EN
  vme_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk    (Clk),
    .RstN   (RstN),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // State register and abort flag.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic, strobe requests and datapath latch enables.
  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    rd_mem_d  = 1'b0;
    wr_mem_d  = 1'b0;
    lat_addr  = 1'b0;
    lat_wdata = 1'b0;
    lat_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          lat_addr = 1'b1;
          if (!wb_we_i) begin
            rd_mem_d = 1'b1;
            state_d  = RD_WAIT;
          end else if (wb_sel_i == SEL_FULL) begin
            lat_wdata = 1'b1;
            wr_mem_d  = 1'b1;
            state_d   = WR_WAIT;
          end else begin
            state_d = ERR;
          end
        end
      end
      RD_WAIT: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (VMERdDone) begin
          lat_rdata = !dropped;
          state_d   = dropped ? IDLE : ACK;
        end else if (tmo_expired) begin
          state_d = dropped ? IDLE : ERR;
        end
      end
      WR_WAIT: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (VMEWrDone) begin
          state_d = dropped ? IDLE : ACK;
        end else if (tmo_expired) begin
          state_d = dropped ? IDLE : ERR;
        end
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes, latched address/write data and returned read data.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
      VMEAddr   <= '0;
      VMEWrData <= '0;
      wb_dat_o  <= '0;
    end else begin
      VMERdMem <= rd_mem_d;
      VMEWrMem <= wr_mem_d;
      if (lat_addr)  VMEAddr   <= wb_adr_i;
      if (lat_wdata) VMEWrData <= wb_dat_i;
      if (lat_rdata) wb_dat_o  <= VMERdData;
    end
  end

  assign wb_ack_o = (state_q == ACK);
  assign wb_err_o = (state_q == ERR);

endmodule
